// File: rtl/tdm_pkg.sv
// Shared types and sizes for the TDM deframer and its slot demultiplexer.
package tdm_pkg;
  localparam int SLOTS   = 8;
  localparam int SEL_W   = 3;
  localparam int FRAME_W = 8;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/demux8.sv
// 1-to-8 demultiplexer: routes input a to output y<s2 s1 s0>; purely combinational, no backpressure.
module demux8 (
  input  logic a,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7
);
  assign y0 = a & ~s2 & ~s1 & ~s0;
  assign y1 = a & ~s2 & ~s1 &  s0;
  assign y2 = a & ~s2 &  s1 & ~s0;
  assign y3 = a & ~s2 &  s1 &  s0;
  assign y4 = a &  s2 & ~s1 & ~s0;
  assign y5 = a &  s2 & ~s1 &  s0;
  assign y6 = a &  s2 &  s1 & ~s0;
  assign y7 = a &  s2 &  s1 &  s0;
endmodule

// File: rtl/tdm_deframer.sv
// Serial 8-slot TDM deframer: tracks frame alignment, assembles each frame into a parallel word.
// frame_valid/sync_err pulse one cycle after the triggering beat; din_valid=0 stalls with no state change.
module tdm_deframer #(
  parameter int SLOTS = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] ch_sel,
  output logic [7:0]       frame_out,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);
  import tdm_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ch_sel_q, ch_sel_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 sync_err_q, sync_err_d;
  logic                 locked_q, locked_d;

  logic                 discard, early, accept;
  logic [FRAME_W-1:0]   slot_y, slot_we;

  always_comb begin
    discard = 1'b0;
    early   = 1'b0;
    if (state_q == HUNT) begin
      discard = ~sync;
    end else begin
      discard = ~sync && (ch_sel_q == '0);
      early   = din_valid && sync && (ch_sel_q != '0);
    end
  end

  assign accept = din_valid & ~discard;

  demux8 u_demux (
    .a  (accept),
    .s2 (ch_sel_q[2]),
    .s1 (ch_sel_q[1]),
    .s0 (ch_sel_q[0]),
    .y0 (slot_y[0]),
    .y1 (slot_y[1]),
    .y2 (slot_y[2]),
    .y3 (slot_y[3]),
    .y4 (slot_y[4]),
    .y5 (slot_y[5]),
    .y6 (slot_y[6]),
    .y7 (slot_y[7])
  );

  // An early marker restarts the frame, so slot 0 is written regardless of ch_sel.
  assign slot_we  = slot_y | {{(FRAME_W-1){1'b0}}, early};
  assign shadow_d = (shadow_q & ~slot_we) | ({FRAME_W{din}} & slot_we);

  always_comb begin
    state_d       = state_q;
    ch_sel_d      = ch_sel_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          ch_sel_d = SEL_W'(1);
          state_d  = COLLECT;
        end
      end else if (early) begin
        sync_err_d = 1'b1;
        ch_sel_d   = SEL_W'(1);
      end else if (discard) begin
        sync_err_d = 1'b1;
        ch_sel_d   = '0;
        state_d    = HUNT;
      end else begin
        if (ch_sel_q == LAST_SLOT) begin
          frame_d       = {din, shadow_q[FRAME_W-2:0]};
          frame_valid_d = 1'b1;
        end
        ch_sel_d = ch_sel_q + SEL_W'(1);
      end
    end
    locked_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      ch_sel_q      <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_sel_q      <= ch_sel_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  assign ch_sel      = ch_sel_q;
  assign frame_out   = frame_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
endmodule

// File: tb/tb_tdm_deframer.sv
// Directed bench for tdm_deframer: each scenario task drives beats and checks outputs #1 after the edge.
module tb_tdm_deframer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [2:0] ch_sel;
  logic [7:0] frame_out;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;

  int checks = 0;
  int errors = 0;

  tdm_deframer #(.SLOTS(8), .SEL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .ch_sel      (ch_sel),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic d, input logic s);
    din = d; sync = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0; sync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL reset_ch_sel got %0d want 0", ch_sel); end
    checks++; if (frame_out !== 8'h00) begin errors++; $display("FAIL reset_frame_out got %h want 00", frame_out); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] f;
    f = 8'h4D;  // slots 0..7 = 1,0,1,1,0,0,1,0
    for (int k = 0; k < 8; k++) begin
      beat(f[k], k == 0);
      if (k < 7) begin
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_early_fv slot %0d got %b want 0", k, frame_valid); end
        checks++; if (ch_sel !== 3'(k + 1)) begin errors++; $display("FAIL basic_ch_sel slot %0d got %0d want %0d", k, ch_sel, k + 1); end
      end
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_fv got %b want 1", frame_valid); end
    checks++; if (frame_out !== 8'h4D) begin errors++; $display("FAIL basic_frame_out got %h want 4d", frame_out); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %b want 1", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL basic_sync_err got %b want 0", sync_err); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL basic_wrap got %0d want 0", ch_sel); end
    idle();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_fv_pulse_width got %b want 0", frame_valid); end
    checks++; if (frame_out !== 8'h4D) begin errors++; $display("FAIL basic_hold got %h want 4d", frame_out); end
  endtask

  task automatic test_stall();
    logic [7:0] f;
    f = 8'h4D;
    for (int k = 0; k < 4; k++) beat(f[k], k == 0);
    for (int c = 0; c < 3; c++) begin
      idle();
      checks++; if (ch_sel !== 3'd4) begin errors++; $display("FAIL stall_ch_sel cyc %0d got %0d want 4", c, ch_sel); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL stall_fv cyc %0d got %b want 0", c, frame_valid); end
    end
    for (int k = 4; k < 8; k++) begin
      beat(f[k], 1'b0);
      if (k < 7) begin
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL stall_early_fv slot %0d got %b want 0", k, frame_valid); end
      end
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL stall_fv got %b want 1", frame_valid); end
    checks++; if (frame_out !== 8'h4D) begin errors++; $display("FAIL stall_frame_out got %h want 4d", frame_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int first_pulse, second_pulse, pulses;
    bits = {8'h3C, 8'hA5};
    first_pulse = -1; second_pulse = -1; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      beat(bits[i], (i % 8) == 0);
      if (frame_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i; else second_pulse = i;
      end
      if (i == 7) begin
        checks++; if (frame_out !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h want a5", frame_out); end
      end
    end
    checks++; if (frame_out !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h want 3c", frame_out); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++; if (second_pulse - first_pulse !== 8) begin errors++; $display("FAIL b2b_spacing got %0d want 8", second_pulse - first_pulse); end
  endtask

  task automatic test_early_sync();
    logic [7:0] f;
    int pulses;
    f = 8'h96;
    pulses = 0;
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
    beat(f[0], 1'b1);  // marker arrives on slot 5
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err got %b want 1", sync_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL early_fv got %b want 0", frame_valid); end
    checks++; if (ch_sel !== 3'd1) begin errors++; $display("FAIL early_ch_sel got %0d want 1", ch_sel); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL early_locked got %b want 1", locked); end
    for (int k = 1; k < 8; k++) begin
      beat(f[k], 1'b0);
      if (k == 1) begin
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL early_err_width got %b want 0", sync_err); end
      end
      if (frame_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1 || frame_valid !== 1'b1) begin errors++; $display("FAIL early_realign_fv got pulses %0d fv %b want 1 on last", pulses, frame_valid); end
    checks++; if (frame_out !== 8'h96) begin errors++; $display("FAIL early_realign_frame got %h want 96", frame_out); end
  endtask

  task automatic test_missing_sync();
    logic [7:0] f;
    beat(1'b1, 1'b0);  // slot-0 beat without marker
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL miss_sync_err got %b want 1", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss_locked got %b want 0", locked); end
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL miss_ch_sel got %0d want 0", ch_sel); end
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 1'b0);
      checks++; if (ch_sel !== 3'd0 || sync_err !== 1'b0 || frame_valid !== 1'b0 || locked !== 1'b0) begin
        errors++; $display("FAIL miss_hunt beat %0d got sel %0d err %b fv %b lk %b want 0 0 0 0", k, ch_sel, sync_err, frame_valid, locked);
      end
    end
    checks++; if (frame_out !== 8'h96) begin errors++; $display("FAIL miss_hold got %h want 96", frame_out); end
    f = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      beat(f[k], k == 0);
      if (k == 0) begin
        checks++; if (locked !== 1'b1 || ch_sel !== 3'd1) begin errors++; $display("FAIL miss_relock got lk %b sel %0d want 1 1", locked, ch_sel); end
      end
    end
    checks++; if (frame_valid !== 1'b1 || frame_out !== 8'h5A) begin errors++; $display("FAIL miss_resume got fv %b frame %h want 1 5a", frame_valid, frame_out); end
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] f;
    for (int k = 0; k < 4; k++) beat(1'b0, k == 0);
    rst = 1'b1;
    beat(1'b1, 1'b0);  // slot 4 with reset asserted
    rst = 1'b0;
    checks++; if (ch_sel !== 3'd0 || frame_out !== 8'h00 || frame_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL rst_mid got sel %0d frame %h fv %b err %b lk %b want 0 00 0 0 0", ch_sel, frame_out, frame_valid, sync_err, locked);
    end
    idle();
    checks++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL rst_no_pulse got fv %b err %b want 0 0", frame_valid, sync_err); end
    f = 8'hFF;
    for (int k = 0; k < 8; k++) beat(f[k], k == 0);
    checks++; if (frame_valid !== 1'b1 || frame_out !== 8'hFF) begin errors++; $display("FAIL rst_recover got fv %b frame %h want 1 ff", frame_valid, frame_out); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_rst_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
